// File: rtl/mult_acc_pkg.sv
// ============================================================================
// Module : mult_acc_pkg
// Brief  : Shared constants for the product accumulator: default widths and
//          FSM state encodings.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_acc_pkg;
  localparam int PROD_W_DEF = 32;
  localparam int ACC_W_DEF  = 40;
  localparam int LEN_W_DEF  = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_HOLD  = 2'd2;
endpackage

`default_nettype wire

// File: rtl/mult_acc_adder.sv
// ============================================================================
// Module : mult_acc_adder
// Brief  : ACC_W + zero-extended PROD_W adder with carry out. When
//          MULT_ACC_SAT_EN is defined the sum clamps to all-ones on carry.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_acc_adder
  import mult_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_in,
  input  logic [PROD_W-1:0] prod_in,
  output logic [ACC_W-1:0]  sum_out,
  output logic              carry_out
);

  logic [ACC_W:0] w_sum;

  assign w_sum     = {1'b0, acc_in} + (ACC_W+1)'(prod_in);
  assign carry_out = w_sum[ACC_W];

`ifdef MULT_ACC_SAT_EN
  // Once clamped, any further non-zero add carries again, so the clamp holds.
  assign sum_out = carry_out ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign sum_out = w_sum[ACC_W-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/mult16u_product_accumulator.sv
// ============================================================================
// Module : mult16u_product_accumulator
// Brief  : Sums cfg_len unsigned products per group and presents the sum with
//          a sticky overflow flag. Optional saturation: MULT_ACC_SAT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult16u_product_accumulator
  import mult_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [LEN_W-1:0]  out_count,
  output logic              out_ovf
);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;

  logic               w_in_fire;
  logic               w_out_fire;
  logic [ACC_W-1:0]   w_sum;
  logic               w_carry;
  logic [LEN_W-1:0]   w_len_cfg;
  logic [LEN_W-1:0]   w_cnt_inc;

  mult_acc_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc_in    (acc_q),
    .prod_in   (in_product),
    .sum_out   (w_sum),
    .carry_out (w_carry)
  );

  assign in_ready   = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
  assign out_valid  = (state_q == ST_HOLD);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_len_cfg  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign w_cnt_inc  = cnt_q + LEN_W'(1);

  assign out_acc    = acc_q;
  assign out_count  = cnt_q;
  assign out_ovf    = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (w_in_fire) begin
          acc_d   = ACC_W'(in_product);
          cnt_d   = LEN_W'(1);
          len_d   = w_len_cfg;
          ovf_d   = 1'b0;
          state_d = (w_len_cfg == LEN_W'(1)) ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        // Length is latched, so cfg_len changes mid-group have no effect here.
        if (w_in_fire) begin
          acc_d = w_sum;
          cnt_d = w_cnt_inc;
          ovf_d = ovf_q | w_carry;
          if (w_cnt_inc == len_q) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (w_out_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult16u_product_accumulator.sv
// ============================================================================
// Module : tb_mult16u_product_accumulator
// Brief  : Directed self-checking bench for the product accumulator; a second
//          narrow-accumulator instance exercises overflow / MULT_ACC_SAT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult16u_product_accumulator;

  localparam int ACC_W_B = 34;

  logic        clk = 1'b0;
  logic        rst;

  logic [7:0]  cfg_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_product;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_acc;
  logic [7:0]  out_count;
  logic        out_ovf;

  logic [7:0]         b_cfg_len;
  logic               b_in_valid;
  logic               b_in_ready;
  logic [31:0]        b_in_product;
  logic               b_out_valid;
  logic               b_out_ready;
  logic [ACC_W_B-1:0] b_out_acc;
  logic [7:0]         b_out_count;
  logic               b_out_ovf;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mult16u_product_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_len    (cfg_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_acc    (out_acc),
    .out_count  (out_count),
    .out_ovf    (out_ovf)
  );

  mult16u_product_accumulator #(.PROD_W(32), .ACC_W(ACC_W_B), .LEN_W(8)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .cfg_len    (b_cfg_len),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_product (b_in_product),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_acc    (b_out_acc),
    .out_count  (b_out_count),
    .out_ovf    (b_out_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Drive one product for exactly one cycle; returns #1 after the edge.
  task automatic send(input logic [31:0] p);
    in_valid   = 1'b1;
    in_product = p;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] p);
    b_in_valid   = 1'b1;
    b_in_product = p;
    @(posedge clk);
    #1;
    b_in_valid   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] sb_sum;
    logic [7:0]  sb_len;
    int          fires;
    int          guard;
    logic        fire_now;

    rst = 1'b1;
    cfg_len = 8'd0; in_valid = 1'b0; in_product = '0; out_ready = 1'b0;
    b_cfg_len = 8'd0; b_in_valid = 1'b0; b_in_product = '0; b_out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);

    // Asynchronous reset mid-group
    cfg_len = 8'd4;
    out_ready = 1'b1;
    send(32'd5);
    send(32'd7);
    chk("mid_acc_partial", out_acc, 12);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_acc", out_acc, 0);
    chk("arst_out_count", out_count, 0);
    chk("arst_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    cfg_len = 8'd2;
    send(32'd10);
    send(32'd20);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_acc", out_acc, 30);
    chk("post_rst_count", out_count, 2);
    tick();
    chk("post_rst_release", out_valid, 0);

    // Four back-to-back products crossing 2^32
    cfg_len = 8'd4;
    send(32'd1);
    send(32'd2);
    send(32'd3);
    send(32'hFFFF_FFFF);
    chk("len4_valid", out_valid, 1);
    chk("len4_acc", out_acc, 64'h01_0000_0005);
    chk("len4_count", out_count, 4);
    chk("len4_ovf", out_ovf, 0);
    chk("len4_in_ready_hold", in_ready, 0);
    tick();
    chk("len4_idle_valid", out_valid, 0);
    chk("len4_idle_ready", in_ready, 1);

    // cfg_len 0 behaves as 1, and cfg_len 1
    cfg_len = 8'd0;
    send(32'h1234);
    chk("len0_valid", out_valid, 1);
    chk("len0_acc", out_acc, 32'h1234);
    chk("len0_count", out_count, 1);
    tick();
    cfg_len = 8'd1;
    send(32'h1234);
    chk("len1_valid", out_valid, 1);
    chk("len1_acc", out_acc, 32'h1234);
    chk("len1_count", out_count, 1);
    tick();

    // Backpressure in HOLD with in_valid asserted
    out_ready = 1'b0;
    cfg_len = 8'd2;
    send(32'd100);
    send(32'd200);
    in_valid = 1'b1;
    in_product = 32'hDEAD;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_acc", out_acc, 300);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    chk("bp_acc_end", out_acc, 300);
    chk("bp_count_end", out_count, 2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    cfg_len = 8'd1;
    send(32'd9);
    chk("bp_next_acc", out_acc, 9);
    chk("bp_next_valid", out_valid, 1);
    tick();

    // Maximum length, all-ones products: fits in 40 bits
    cfg_len = 8'd255;
    for (int i = 0; i < 255; i++) send(32'hFFFF_FFFF);
    chk("max_valid", out_valid, 1);
    chk("max_acc", out_acc, 64'hFE_FFFF_FF01);
    chk("max_count", out_count, 255);
    chk("max_ovf", out_ovf, 0);
    tick();

    // Random gaps with cfg_len changing mid-group
    for (int g = 0; g < 2; g++) begin
      cfg_len = 8'd5;
      sb_len = 8'd5;
      sb_sum = '0;
      fires = 0;
      guard = 0;
      while (fires < sb_len && guard < 200) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_product = $urandom;
        fire_now = in_valid && in_ready;
        if (fire_now) sb_sum = sb_sum + {32'd0, in_product};
        tick();
        if (fire_now) begin
          fires++;
          cfg_len = 8'd3;
        end
        guard++;
      end
      in_valid = 1'b0;
      chk("rnd_timeout", (guard < 200), 1);
      chk("rnd_valid", out_valid, 1);
      chk("rnd_acc", out_acc, {24'd0, sb_sum[39:0]});
      chk("rnd_count", out_count, sb_len);
      chk("rnd_ovf", out_ovf, (sb_sum[63:40] != 0));
      tick();
    end

    // Overflow on a 34-bit accumulator: 6 x 0xFFFF_FFFF = 0x5_FFFF_FFFA
    b_cfg_len = 8'd6;
    for (int i = 0; i < 6; i++) send_b(32'hFFFF_FFFF);
    chk("ovf_valid", b_out_valid, 1);
    chk("ovf_count", b_out_count, 6);
    chk("ovf_flag", b_out_ovf, 1);
`ifdef MULT_ACC_SAT_EN
    chk("ovf_acc_sat", b_out_acc, 64'h3_FFFF_FFFF);
`else
    chk("ovf_acc_wrap", b_out_acc, 64'h1_FFFF_FFFA);
`endif
    tick();
    // Four products sit exactly below the limit: no overflow
    b_cfg_len = 8'd4;
    for (int i = 0; i < 4; i++) send_b(32'hFFFF_FFFF);
    chk("nearmax_acc", b_out_acc, 64'h3_FFFF_FFFC);
    chk("nearmax_ovf", b_out_ovf, 0);
    tick();
    b_cfg_len = 8'd1;
    send_b(32'd5);
    chk("ovf_clear_acc", b_out_acc, 5);
    chk("ovf_clear_flag", b_out_ovf, 0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
